// File: rtl/led_seq_pkg.sv
// Shared state encoding, default widths and prescale-counter sizing for the
// LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 4;
  localparam int PRESCALE_DEF = 50000000;

  function automatic int cnt_width(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

  localparam int CNT_W_DEF = cnt_width(PRESCALE_DEF);

endpackage

// File: rtl/led_seq_prescaler.sv
// Hold-phase cycle counter: synchronous clear, count enable, and a terminal
// pulse on the last hold cycle (count == PRESCALE-3).
module led_seq_prescaler
  import led_seq_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(PRESCALE);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      count_r <= {CNT_W{1'b0}};
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  assign tc = en && (count_r == CNT_W'(PRESCALE - 3));

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps a 1-cycle-latency pattern ROM at a prescaled rate onto the LEDs.
// Build option: LED_SEQ_BOUNCE_EN selects ping-pong instead of wrap-around addressing.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_LO  = 0,
  parameter int ADDR_HI  = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              decouple,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic [DATA_W-1:0] led,
  output logic              busy,
  output logic              wrap
);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic              wrap_nxt_s;
  logic              load_led_s;
  logic              clr_s;
  logic              cnt_en_s;
  logic              tc_s;
`ifdef LED_SEQ_BOUNCE_EN
  logic              dir_up_r;
  logic              dir_up_nxt_s;
`endif

  assign clr_s    = (state_r == CAPTURE);
  assign cnt_en_s = (state_r == HOLD) && !decouple;

  led_seq_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_s),
    .en    (cnt_en_s),
    .tc    (tc_s)
  );

  // Next-state, address advance and LED load decisions.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = rom_addr;
    wrap_nxt_s  = 1'b0;
    load_led_s  = 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
    dir_up_nxt_s = dir_up_r;
`endif
    case (state_r)
      IDLE: begin
        if (run && !decouple) state_nxt_s = FETCH;
        else                  state_nxt_s = IDLE;
      end
      FETCH: begin
        if (decouple) state_nxt_s = IDLE;
        else          state_nxt_s = CAPTURE;
      end
      CAPTURE: begin
        // A decoupled ROM may return garbage, so the partial fetch is dropped.
        if (decouple) begin
          state_nxt_s = IDLE;
        end else begin
          load_led_s  = 1'b1;
          state_nxt_s = run ? HOLD : IDLE;
        end
      end
      HOLD: begin
        if (decouple) begin
          state_nxt_s = IDLE;
        end else if (tc_s) begin
          state_nxt_s = run ? FETCH : IDLE;
`ifdef LED_SEQ_BOUNCE_EN
          // Direction flips on arrival at an endpoint so it is never repeated.
          if (dir_up_r) begin
            addr_nxt_s = rom_addr + ADDR_W'(1);
            if (rom_addr == ADDR_W'(ADDR_HI - 1)) begin
              dir_up_nxt_s = 1'b0;
              wrap_nxt_s   = 1'b1;
            end else begin
              dir_up_nxt_s = 1'b1;
            end
          end else begin
            addr_nxt_s = rom_addr - ADDR_W'(1);
            if (rom_addr == ADDR_W'(ADDR_LO + 1)) begin
              dir_up_nxt_s = 1'b1;
              wrap_nxt_s   = 1'b1;
            end else begin
              dir_up_nxt_s = 1'b0;
            end
          end
`else
          if (rom_addr == ADDR_W'(ADDR_HI)) begin
            addr_nxt_s = ADDR_W'(ADDR_LO);
            wrap_nxt_s = 1'b1;
          end else begin
            addr_nxt_s = rom_addr + ADDR_W'(1);
          end
`endif
        end else if (!run) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; rom_en/busy are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rom_addr <= ADDR_W'(ADDR_LO);
      rom_en   <= 1'b0;
      led      <= {DATA_W{1'b0}};
      busy     <= 1'b0;
      wrap     <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
      dir_up_r <= 1'b1;
`endif
    end else begin
      state_r  <= state_nxt_s;
      rom_addr <= addr_nxt_s;
      rom_en   <= (state_nxt_s == FETCH) || (state_nxt_s == CAPTURE);
      busy     <= (state_nxt_s != IDLE);
      wrap     <= wrap_nxt_s;
      if (load_led_s) begin
        led <= rom_data;
      end
`ifdef LED_SEQ_BOUNCE_EN
      dir_up_r <= dir_up_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: directed vector table, corner
// sequences, and randomized run/decouple/reset against a cycle-phase model.
module tb_led_pattern_sequencer;

  localparam int P  = 4;
  localparam int LO = 0;
  localparam int HI = 3;
  localparam int N  = HI - LO + 1;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        decouple;
  logic [3:0]  rom_data;
  logic [11:0] rom_addr;
  logic        rom_en;
  logic [3:0]  led;
  logic        busy;
  logic        wrap;

  logic [3:0] rom_mem [4096];

  int n_checks;
  int n_pass;

  // Model state: active flag, phase within the P-cycle period, pattern position.
  bit         m_active;
  int         m_phase;
  int         m_pos;
  logic [3:0] m_led;
  bit         m_wrap;

  typedef struct {
    logic        run;
    logic        dec;
    logic [3:0]  led;
    logic [11:0] addr;
    logic        en;
    logic        busy;
    logic        wrap;
  } vec_t;

  vec_t tv[$];

`ifdef LED_SEQ_BOUNCE_EN
  localparam logic        W13 = 1'b1;
  localparam logic        W17 = 1'b0;
  localparam logic [11:0] A17 = 12'd2;
  localparam logic [3:0]  L19 = 4'd2;
`else
  localparam logic        W13 = 1'b0;
  localparam logic        W17 = 1'b1;
  localparam logic [11:0] A17 = 12'd0;
  localparam logic [3:0]  L19 = 4'd8;
`endif

  led_pattern_sequencer #(
    .PRESCALE (P),
    .ADDR_W   (12),
    .DATA_W   (4),
    .ADDR_LO  (LO),
    .ADDR_HI  (HI)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .decouple (decouple),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .led      (led),
    .busy     (busy),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: 1-cycle latency, output forced to zero while not enabled.
  initial rom_data = 4'd0;
  always @(posedge clk) rom_data <= rom_en ? rom_mem[rom_addr] : 4'd0;

  function automatic int mdl_addr();
`ifdef LED_SEQ_BOUNCE_EN
    return (m_pos < N) ? LO + m_pos : LO + 2 * (N - 1) - m_pos;
`else
    return LO + m_pos;
`endif
  endfunction

  function automatic void mdl_advance();
`ifdef LED_SEQ_BOUNCE_EN
    m_pos  = (m_pos + 1) % (2 * (N - 1));
    m_wrap = (m_pos == N - 1) || (m_pos == 0);
`else
    m_pos  = (m_pos + 1) % N;
    m_wrap = (m_pos == 0);
`endif
  endfunction

  function automatic void mdl_reset();
    m_active = 1'b0;
    m_phase  = 0;
    m_pos    = 0;
    m_led    = 4'd0;
    m_wrap   = 1'b0;
  endfunction

  // Phases 0/1 fetch the ROM, phases 2..P-1 hold; an update every P cycles.
  function automatic void mdl_edge();
    m_wrap = 1'b0;
    if (!m_active) begin
      if (run && !decouple) begin
        m_active = 1'b1;
        m_phase  = 0;
      end
    end else if (decouple) begin
      m_active = 1'b0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_led = rom_mem[mdl_addr()];
      if (run) m_phase = 2;
      else     m_active = 1'b0;
    end else if (m_phase == P - 1) begin
      mdl_advance();
      if (run) m_phase = 0;
      else     m_active = 1'b0;
    end else if (!run) begin
      m_active = 1'b0;
    end else begin
      m_phase = m_phase + 1;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("mdl_led",  32'(led),      32'(m_led));
    chk("mdl_addr", 32'(rom_addr), 32'(mdl_addr()));
    chk("mdl_en",   32'(rom_en),   32'(m_active && (m_phase < 2)));
    chk("mdl_busy", 32'(busy),     32'(m_active));
    chk("mdl_wrap", 32'(wrap),     32'(m_wrap));
  endtask

  task automatic step();
    logic [3:0] led_before;
    logic       en_before;
    led_before = led;
    en_before  = rom_en;
    @(posedge clk);
    mdl_edge();
    #1;
    chk_model();
    if (led !== led_before) chk("led_needs_prior_en", 32'(en_before), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk("rst_addr", 32'(rom_addr), 32'(LO));
    chk("rst_led",  32'(led),      32'd0);
    chk("rst_en",   32'(rom_en),   32'd0);
    chk("rst_busy", 32'(busy),     32'd0);
    chk("rst_wrap", 32'(wrap),     32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 4'(i);
    rom_mem[0] = 4'd8;
    rom_mem[1] = 4'd4;
    rom_mem[2] = 4'd2;
    rom_mem[3] = 4'd1;
    rst_n    = 1'b0;
    run      = 1'b0;
    decouple = 1'b0;
    mdl_reset();

    //            run   dec   led    addr    en    busy  wrap
    tv.push_back('{1'b1, 1'b0, 4'd0, 12'd0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd0, 12'd0, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd8, 12'd0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd8, 12'd0, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd8, 12'd1, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd8, 12'd1, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd4, 12'd1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd4, 12'd1, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd4, 12'd2, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd4, 12'd2, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd2, 12'd2, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd2, 12'd2, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd2, 12'd3, 1'b1, 1'b1, W13});
    tv.push_back('{1'b1, 1'b0, 4'd2, 12'd3, 1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd1, 12'd3, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd1, 12'd3, 1'b0, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 4'd1, A17,   1'b1, 1'b1, W17});
    tv.push_back('{1'b1, 1'b0, 4'd1, A17,   1'b1, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, L19,  A17,   1'b0, 1'b1, 1'b0});

    @(posedge clk);
    #1;
    do_reset();

    // Directed sequence from reset.
    for (int i = 0; i < tv.size(); i++) begin
      run      = tv[i].run;
      decouple = tv[i].dec;
      step();
      chk($sformatf("tv%0d_led", i + 1),  32'(led),      32'(tv[i].led));
      chk($sformatf("tv%0d_addr", i + 1), 32'(rom_addr), 32'(tv[i].addr));
      chk($sformatf("tv%0d_en", i + 1),   32'(rom_en),   32'(tv[i].en));
      chk($sformatf("tv%0d_busy", i + 1), 32'(busy),     32'(tv[i].busy));
      chk($sformatf("tv%0d_wrap", i + 1), 32'(wrap),     32'(tv[i].wrap));
    end

    // Drop run in the first HOLD cycle after led=4, then resume.
    do_reset();
    run = 1'b1;
    repeat (7) step();
    chk("drop_pre_led", 32'(led), 32'd4);
    run = 1'b0;
    step();
    chk("drop_busy", 32'(busy),     32'd0);
    chk("drop_led",  32'(led),      32'd4);
    chk("drop_addr", 32'(rom_addr), 32'd1);
    chk("drop_en",   32'(rom_en),   32'd0);
    run = 1'b1;
    step();
    chk("refetch_en",   32'(rom_en),   32'd1);
    chk("refetch_addr", 32'(rom_addr), 32'd1);
    step();
    step();
    chk("refetch_led", 32'(led), 32'(rom_mem[1]));
    step();
    chk("pre_rst_addr", 32'(rom_addr), 32'd1);
    // Asynchronous reset in the middle of HOLD.
    do_reset();

    // Decouple during CAPTURE at address 1.
    run = 1'b1;
    repeat (6) step();
    chk("dec_pre_en", 32'(rom_en), 32'd1);
    decouple = 1'b1;
    step();
    chk("dec_en",   32'(rom_en),   32'd0);
    chk("dec_led",  32'(led),      32'd8);
    chk("dec_addr", 32'(rom_addr), 32'd1);
    chk("dec_busy", 32'(busy),     32'd0);
    step();
    chk("dec_hold_busy", 32'(busy), 32'd0);
    decouple = 1'b0;
    step();
    chk("resume_en",   32'(rom_en),   32'd1);
    chk("resume_addr", 32'(rom_addr), 32'd1);
    step();
    step();
    chk("resume_led", 32'(led), 32'd4);

    // Randomized run/decouple with occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) run = ~run;
      decouple = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 399) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
